div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_pkg.sv | 12 +
 rtl/div_sched_if.sv | 32 +++
 rtl/div_sched_core.sv | 35 +++
 rtl/div_sched.sv | 124 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencer: FSM encoding and parameter defaults.
package div_pkg;

    localparam int unsigned DwDef    = 8;
    localparam int unsigned DepthDef = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

endpackage

// File: rtl/div_sched_if.sv
// Control, table-write and status bundle of div_sched.
interface div_sched_if
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDef,
    parameter int unsigned DW    = DwDef
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic            start;
    logic            stop;
    logic            tick;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [DW-1:0]   d_out;
    logic            fout;
    logic [AW-1:0]   step;
    logic            busy;
    logic            done;

    modport master (
        output start, stop, tick, wr_en, wr_addr, wr_data,
        input  d_out, fout, step, busy, done
    );

    modport slave (
        input  start, stop, tick, wr_en, wr_addr, wr_data,
        output d_out, fout, step, busy, done
    );

endinterface

// File: rtl/div_sched_core.sv
// Programmable clock-enable divider: counts d..2^DW-1 and toggles fout on wrap.
module div_core
    import div_pkg::*;
#(
    parameter int unsigned DW = DwDef
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic          fout
);

    logic [DW-1:0] cnt_q;
    logic          fout_q;

    // en low clears; load reloads the counter while holding fout steady.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            fout_q <= 1'b0;
        end else if (load) begin
            cnt_q <= d;
        end else if (cnt_q == '1) begin
            cnt_q  <= d;
            fout_q <= ~fout_q;
        end else begin
            cnt_q <= cnt_q + DW'(1);
        end
    end

    assign fout = fout_q;

endmodule

// File: rtl/div_sched.sv
// Table-driven divider sequencer; define DIV_SCHED_LOOP_EN to wrap after the last entry.
module div_sched
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDef,
    parameter int unsigned DW    = DwDef
) (
    input logic       clk,
    input logic       rst,
    div_sched_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LastStep = AW'(DEPTH - 1);

    logic [2*DW-1:0] table_q [DEPTH];
    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   step_q, step_d;
    logic [DW-1:0]   durcnt_q, durcnt_d;
    logic [DW-1:0]   d_q, d_d;
    logic [DW-1:0]   ent_d, ent_dur;
    logic            busy_d;
    logic            core_en, core_load;
    logic [DW-1:0]   core_d;

    assign {ent_dur, ent_d} = table_q[step_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        durcnt_d = durcnt_q;
        d_d      = d_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d = StLoad;
                    step_d  = '0;
                end
            end
            StLoad: begin
                durcnt_d = ent_dur;
                d_d      = ent_d;
                if (bus.stop || ent_dur == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StDone;
                end else if (bus.tick) begin
                    durcnt_d = durcnt_q - DW'(1);
                    if (durcnt_q == DW'(1)) begin
                        if (step_q != LastStep) begin
                            step_d  = step_q + AW'(1);
                            state_d = StLoad;
                        end else begin
`ifdef DIV_SCHED_LOOP_EN
                            step_d  = '0;
                            state_d = StLoad;
`else
                            state_d = StDone;
`endif
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            durcnt_q <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            durcnt_q <= durcnt_d;
            d_q      <= d_d;
        end
    end

    // Load is also asserted on the edge into LOAD so fout holds across entry changes.
    assign busy_d    = (state_d == StLoad) || (state_d == StRun);
    assign core_en   = busy_d;
    assign core_load = (state_q == StLoad) || (state_d == StLoad);
    assign core_d    = (state_q == StLoad) ? ent_d : d_q;

    div_core #(
        .DW(DW)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (core_en),
        .load(core_load),
        .d   (core_d),
        .fout(bus.fout)
    );

    assign bus.d_out = d_q;
    assign bus.step  = step_q;
    assign bus.busy  = (state_q == StLoad) || (state_q == StRun);
    assign bus.done  = (state_q == StDone);

endmodule
